// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings and the decoded-instruction record
// used by decode, hazard and execute logic.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] instr_index;
        logic        reg_write;
        logic        mem2reg;
        logic        mem_en;
        logic        mem_rd;
        logic        byte_en;
        logic        branch;
        logic        bne;
        logic        jump;
        logic        jr;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational MIPS field/control decode with source-usage flags.
// DECODE_BYTE_OPS_EN enables LB/SB; otherwise they decode as illegal NOPs.
module decode_comb
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o,
    output logic        use_rs_o,
    output logic        use_rt_o
);

    logic [5:0] op;
    assign op = instr_i[31:26];

    always_comb begin
        dec_o             = '0;
        use_rs_o          = 1'b0;
        use_rt_o          = 1'b0;
        dec_o.opcode      = op;
        dec_o.funct       = instr_i[5:0];
        dec_o.rs          = instr_i[25:21];
        dec_o.rt          = instr_i[20:16];
        dec_o.shamt       = instr_i[10:6];
        dec_o.imm16       = instr_i[15:0];
        dec_o.instr_index = instr_i[25:0];
        dec_o.dest        = instr_i[20:16];
        dec_o.mem2reg     = 1'b1;

        case (op)
            OP_RTYPE: begin
                use_rs_o   = 1'b1;
                dec_o.dest = instr_i[15:11];
                if (instr_i[5:0] == FN_JR) begin
                    dec_o.jr = 1'b1;
                end else begin
                    use_rt_o        = 1'b1;
                    dec_o.reg_write = 1'b1;
                end
            end
            OP_J:   dec_o.jump = 1'b1;
            OP_JAL: begin
                dec_o.jump      = 1'b1;
                dec_o.dest      = REG_RA;
                dec_o.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                use_rs_o     = 1'b1;
                use_rt_o     = 1'b1;
                dec_o.branch = 1'b1;
                dec_o.bne    = (op == OP_BNE);
            end
            OP_LW: begin
                use_rs_o        = 1'b1;
                dec_o.mem_rd    = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.mem2reg   = 1'b0;
            end
            OP_SW: begin
                use_rs_o     = 1'b1;
                use_rt_o     = 1'b1;
                dec_o.mem_en = 1'b1;
            end
`ifdef DECODE_BYTE_OPS_EN
            OP_LB: begin
                use_rs_o        = 1'b1;
                dec_o.mem_rd    = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.mem2reg   = 1'b0;
                dec_o.byte_en   = 1'b1;
            end
            OP_SB: begin
                use_rs_o      = 1'b1;
                use_rt_o      = 1'b1;
                dec_o.mem_en  = 1'b1;
                dec_o.byte_en = 1'b1;
            end
`endif
            default: begin
                if (op[5:3] == 3'b001) begin
                    use_rs_o        = 1'b1;
                    dec_o.reg_write = 1'b1;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
        endcase

        // Writes to $0 are architecturally discarded.
        if (dec_o.dest == 5'd0)
            dec_o.reg_write = 1'b0;
    end

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage with ID/EX register, valid/ready handshakes and load-use stall.
// 1-cycle latency; stalls fetch and emits bubbles while a load result is still in flight.
module decode_pipe
    import mips_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      dest,
    output logic [4:0]      shamt,
    output logic [XLEN-1:0] imm,
    output logic [25:0]     instr_index,
    output logic            reg_write,
    output logic            mem2reg,
    output logic            mem_en,
    output logic            mem_rd,
    output logic            byte_en,
    output logic            branch,
    output logic            bne,
    output logic            jump,
    output logic            jr,
    output logic            illegal,
    output logic            stall
);

    dec_t                      dec, out_q, out_d;
    logic                      use_rs, use_rt;
    logic                      out_valid_q, out_valid_d;
    logic [XLEN-1:0]           imm_q, imm_d;
    logic [LOAD_LAT-1:0]       sb_vld_q, sb_vld_d;
    logic [LOAD_LAT-1:0][4:0]  sb_dst_q, sb_dst_d;
    logic                      hazard, accept, push;

    decode_comb u_decode_comb (
        .instr_i  (instruction),
        .dec_o    (dec),
        .use_rs_o (use_rs),
        .use_rt_o (use_rt)
    );

    function automatic logic src_hit(input dec_t d, input logic urs, input logic urt,
                                     input logic [4:0] dst);
        return (urs && d.rs != 5'd0 && d.rs == dst) ||
               (urt && d.rt != 5'd0 && d.rt == dst);
    endfunction

    // The last scoreboard entry is already forwardable, so it never blocks.
    always_comb begin
        hazard = out_valid_q && out_q.mem_rd && src_hit(dec, use_rs, use_rt, out_q.dest);
        for (int i = 0; i < LOAD_LAT - 1; i++)
            if (sb_vld_q[i] && src_hit(dec, use_rs, use_rt, sb_dst_q[i]))
                hazard = 1'b1;
    end

    assign in_ready = !reset && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign push     = out_valid_q && out_ready && out_q.mem_rd;
    assign stall    = !reset && in_valid && hazard;

    always_comb begin
        out_d       = out_q;
        imm_d       = imm_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = dec;
            imm_d       = {{(XLEN-16){dec.imm16[15]}}, dec.imm16};
            out_valid_d = 1'b1;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end

        sb_vld_d = sb_vld_q;
        sb_dst_d = sb_dst_q;
        if (out_ready) begin
            sb_vld_d[0] = push;
            sb_dst_d[0] = out_q.dest;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_vld_d[i] = sb_vld_q[i-1];
                sb_dst_d[i] = sb_dst_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            imm_q       <= '0;
            out_valid_q <= 1'b0;
            sb_vld_q    <= '0;
            sb_dst_q    <= '0;
        end else begin
            out_q       <= out_d;
            imm_q       <= imm_d;
            out_valid_q <= out_valid_d;
            sb_vld_q    <= sb_vld_d;
            sb_dst_q    <= sb_dst_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign opcode      = out_q.opcode;
    assign funct       = out_q.funct;
    assign rs          = out_q.rs;
    assign rt          = out_q.rt;
    assign dest        = out_q.dest;
    assign shamt       = out_q.shamt;
    assign imm         = imm_q;
    assign instr_index = out_q.instr_index;
    assign reg_write   = out_q.reg_write;
    assign mem2reg     = out_q.mem2reg;
    assign mem_en      = out_q.mem_en;
    assign mem_rd      = out_q.mem_rd;
    assign byte_en     = out_q.byte_en;
    assign branch      = out_q.branch;
    assign bne         = out_q.bne;
    assign jump        = out_q.jump;
    assign jr          = out_q.jr;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode vector table plus hazard, hold, flush and reset sequences.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instruction, imm;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, dest, shamt;
    logic [25:0] instr_index;
    logic        reg_write, mem2reg, mem_en, mem_rd, byte_en, branch, bne, jump, jr, illegal;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .LOAD_LAT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .dest(dest), .shamt(shamt),
        .imm(imm), .instr_index(instr_index), .reg_write(reg_write), .mem2reg(mem2reg),
        .mem_en(mem_en), .mem_rd(mem_rd), .byte_en(byte_en), .branch(branch), .bne(bne),
        .jump(jump), .jr(jr), .illegal(illegal), .stall(stall)
    );

    // {reg_write, mem2reg, mem_en, mem_rd, byte_en, branch, bne, jump, jr, illegal}
    wire [9:0] ctl = {reg_write, mem2reg, mem_en, mem_rd, byte_en, branch, bne, jump, jr, illegal};

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [9:0]  ctl;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls, bubbles, got;
        logic [31:0] seq_instr[3];
        logic [4:0]  seq_dest[3];

        vecs[0]  = '{32'h01085020, 5'd10, 32'h00005020, 10'b1100000000}; // ADD
        vecs[1]  = '{32'h0C000010, 5'd31, 32'h00000010, 10'b1100000100}; // JAL
        vecs[2]  = '{32'h2000FFFF, 5'd0,  32'hFFFFFFFF, 10'b0100000000}; // ADDI $0
        vecs[3]  = '{32'h8D280000, 5'd8,  32'h00000000, 10'b1001000000}; // LW
        vecs[4]  = '{32'hAD280004, 5'd8,  32'h00000004, 10'b0110000000}; // SW
        vecs[5]  = '{32'h1509FFFE, 5'd9,  32'hFFFFFFFE, 10'b0100011000}; // BNE
        vecs[6]  = '{32'h03E00008, 5'd0,  32'h00000008, 10'b0100000010}; // JR
        vecs[7]  = '{32'h08000100, 5'd0,  32'h00000100, 10'b0100000100}; // J
        vecs[8]  = '{32'hFC000000, 5'd0,  32'h00000000, 10'b0100000001}; // bad opcode
`ifdef DECODE_BYTE_OPS_EN
        vecs[9]  = '{32'hA1280004, 5'd8,  32'h00000004, 10'b0110100000}; // SB
        vecs[10] = '{32'h81280000, 5'd8,  32'h00000000, 10'b1001100000}; // LB
`else
        vecs[9]  = '{32'hA1280004, 5'd8,  32'h00000004, 10'b0100000001}; // SB
        vecs[10] = '{32'h81280000, 5'd8,  32'h00000000, 10'b0100000001}; // LB
`endif
        vecs[11] = '{32'h11090003, 5'd9,  32'h00000003, 10'b0100010000}; // BEQ
        vecs[12] = '{32'h34058000, 5'd5,  32'hFFFF8000, 10'b1100000000}; // ORI

        // Reset with a valid instruction presented
        reset = 1'b1; in_valid = 1'b1; instruction = 32'h01085020; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_stall",     {31'd0, stall}, 32'd0);
        chk("rst_ctl",       {22'd0, ctl}, 32'd0);
        chk("rst_fields",    {opcode, funct, rs, rt, dest, shamt}, 32'd0);
        chk("rst_imm",       imm, 32'd0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; instruction = vecs[i].instr;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_dest", i), {27'd0, dest}, {27'd0, vecs[i].dest});
            chk($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("vec%0d_ctl", i), {22'd0, ctl}, {22'd0, vecs[i].ctl});
            chk($sformatf("vec%0d_index", i), {6'd0, instr_index}, {6'd0, vecs[i].instr[25:0]});
            repeat (3) tick();
        end

        // Load-use: LW $8 then ADD $10,$8,$8
        in_valid = 1'b1; instruction = 32'h8D280000;
        tick();
        chk("lw_issued", {31'd0, out_valid && mem_rd}, 32'd1);
        instruction = 32'h01085020;
        stalls = 0; bubbles = 0; got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            #1;
            if (stall) stalls++;
            tick();
            if (out_valid && opcode == 6'd0) begin
                got = 1;
                in_valid = 1'b0;
            end else if (!out_valid) begin
                bubbles++;
            end
        end
        in_valid = 1'b0;
        chk("lu_add_seen", got, 1);
        chk("lu_stalls", stalls, 2);
        chk("lu_bubbles", bubbles, 2);
        chk("lu_add_dest", {27'd0, dest}, 32'd10);
        chk("lu_add_rw", {31'd0, reg_write}, 32'd1);
        repeat (3) tick();

        // Back-to-back independent instructions at full rate
        seq_instr[0] = 32'h01085020; seq_dest[0] = 5'd10;
        seq_instr[1] = 32'h34058000; seq_dest[1] = 5'd5;
        seq_instr[2] = 32'h11090003; seq_dest[2] = 5'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instruction = seq_instr[k];
            tick();
            chk($sformatf("tput%0d", k), {26'd0, out_valid, dest}, {26'd0, 1'b1, seq_dest[k]});
        end
        in_valid = 1'b0;
        tick();

        // Output hold under backpressure, then flush
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h34058000;
        tick();
        instruction = 32'h01085020;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("hold%0d_out", c), {26'd0, out_valid, dest}, {26'd0, 1'b1, 5'd5});
            chk($sformatf("hold%0d_imm", c), imm, 32'hFFFF8000);
        end
        flush = 1'b1;
        tick();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Flush wins over a simultaneous handshake
        in_valid = 1'b1; instruction = 32'h34058000;
        tick();
        instruction = 32'h01085020; flush = 1'b1;
        tick();
        chk("flush_hs_out_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) tick();

        // Reset during a load-use stall drops everything
        in_valid = 1'b1; instruction = 32'h8D280000;
        tick();
        instruction = 32'h01085020;
        #1;
        chk("rs_stall_before", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_stall", {31'd0, stall}, 32'd0);
        chk("rs_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rs_in_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rs_add_out", {26'd0, out_valid, dest}, {26'd0, 1'b1, 5'd10});
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered, handshaked instruction-decode stage for the MIPS core, replacing the purely combinational decoder between fetch and execute. It decodes one 32-bit instruction per cycle into fields and control bits, holds them in an ID/EX register, and detects load-use hazards against a parametrised load-latency scoreboard. On a hazard it stalls fetch and inserts bubbles. Every output is a defined 0/1 level; no output is ever driven to Z.

## Interface
- XLEN, 32: width of the sign-extended immediate output.
- LOAD_LAT, 2: cycles, 1..4, after issue before a load result can be forwarded; this is the scoreboard depth.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid / in_ready  in/out  1  fetch handshake.
- instruction  in  32  instruction word.
- flush  in  1  drops the held instruction (branch/jump redirect).
- out_valid / out_ready  out/in  1  execute handshake.
- opcode, funct  out  6 each.
- rs, rt, dest  out  5 each; dest is rd for R-type, 31 for JAL, otherwise rt.
- shamt  out  5.
- imm  out  XLEN  sign-extended instruction[15:0].
- instr_index  out  26.
- reg_write, mem2reg, mem_en, mem_rd, byte_en, branch, bne, jump, jr, illegal  out  1 each.
- stall  out  1  hazard stall active this cycle.
- One clock, `clk`. Reset `reset` is synchronous, active-high.

## Operation
- Decode classes by opcode:
  - 000000: R-type; funct 001000 is JR.
  - 000010: J.
  - 000011: JAL.
  - 000100 / 000101: BEQ / BNE.
  - 100000 / 100011: LB / LW.
  - 101000 / 101011: SB / SW.
  - 001xxx: immediate ALU.
  - Anything else: illegal, decoded as a NOP with illegal=1.
- Unused control bits are 0.
- reg_write=1 for R-type (not JR), JAL, loads and immediate ALU; forced to 0 when dest==0.
- mem2reg=0 only for loads. mem_rd=1 for loads; mem_en=1 for stores.
- Source usage:
  - rs is read by R-type, JR, branches, loads, stores and immediate ALU.
  - rt is read by R-type (except JR), branches and stores.
- Scoreboard: LOAD_LAT entries of {valid, dest}. When an output load handshakes (out_valid&&out_ready), its dest is pushed into entry 0. All entries shift one place whenever out_ready=1.
- Hazard: a used, nonzero source of the incoming instruction equals the dest of a valid load held in the output register or in any scoreboard entry except the last.
- Acceptance: in_ready = !flush && !hazard && (!out_valid || out_ready). stall = in_valid && hazard.
- While stalled, the output empties after its handshake; out_valid stays 0 (bubble) until the hazard clears.
- flush: clears out_valid next cycle and blocks acceptance that cycle. The scoreboard is kept, because issued loads still complete.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented on the outputs after edge N with out_valid=1.
- Outputs hold stable while out_valid && !out_ready.
- Reset values: out_valid=0; all control bits, fields, imm and stall are 0; the scoreboard is cleared. Reset mid-stall or mid-transfer drops all state, and in_ready is 0 during reset.
- If flush and a handshake occur in the same cycle, flush wins and nothing is accepted.
- Maximum hazard bubbles between a load and a dependent consumer: LOAD_LAT.
- Throughput is one instruction per cycle with no hazards and out_ready held at 1.

## Configuration
- DECODE_BYTE_OPS_EN defined: LB and SB decode as loads/stores with byte_en=1.
- DECODE_BYTE_OPS_EN undefined: LB and SB are illegal (NOP, illegal=1), byte_en is tied to 0, and a byte load never enters the scoreboard.

## Structure
- Shared package `mips_pkg`: opcode and funct constants, and the decoded-control struct typedef. The execute and hazard logic reuse these.
- One sub-module, `decode_comb`: pure combinational field/control decode including source-usage flags. `decode_pipe` owns the handshake, the registers and the scoreboard.

## Test plan
- Reset asserted with in_valid=1 and instruction 0x01085020 → out_valid=0, in_ready=0, all outputs 0.
- LW $8,0($9) (0x8D280000) then ADD $10,$8,$8 (0x01085020) with LOAD_LAT=2 and out_ready=1:
  - 2 bubble cycles with stall=1.
  - ADD then appears with dest=10 and reg_write=1.
- JAL (0x0C000010) → jump=1, dest=31, reg_write=1, instr_index=0x0000010.
- ADDI $0,$0,-1 (0x2000FFFF) → imm=0xFFFFFFFF, reg_write=0.
- out_ready held 0 for 3 cycles with out_valid=1 → outputs stable and in_ready=0. Asserting flush → out_valid=0 next cycle.
- SB (0xA1280004):
  - With the macro: mem_en=1, byte_en=1.
  - Without the macro: illegal=1, mem_en=0.
